// File: rtl/pc_fetch_control_pkg.sv
// Shared definitions for the PC / instruction-fetch sequencer:
// FSM state encoding (3 bits), reset PC default, PC step, instruction width
// and the next-PC mux selector.
package pc_fetch_control_pkg;

  localparam int unsigned INST_W           = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned PC_STEP_DEFAULT  = 4;
  localparam logic [31:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

  // ST_TRAP is only reachable when PC_MISALIGN_TRAP_EN is defined.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_TRAP  = 3'd5
  } fetch_state_e;

  typedef enum logic [1:0] {
    SEL_HOLD = 2'd0,
    SEL_INC  = 2'd1,
    SEL_TGT  = 2'd2
  } pc_sel_e;

  // Clear the byte offset of an address so it points at a whole word.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & WORD_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/pc_fetch_control_if.sv
// Fetch-side bus: the instruction-memory request/response channel and the
// instruction channel towards decode.
// Handshake rule for both valid/ready pairs: a transfer happens on a rising
// clock edge where valid and ready are both 1; once valid is raised the
// payload stays stable and valid stays high until that transfer (or a taken
// redirect, which withdraws it). The imem response has no ready: exactly one
// response pulse returns for each accepted request.
interface pc_fetch_control_if;

  logic        o_ImemReqValid_1;
  logic        i_ImemReqReady_1;
  logic [31:0] o_ImemAddr_32;
  logic        i_ImemRespValid_1;
  logic [31:0] i_ImemRespData_32;
  logic        o_InstValid_1;
  logic        i_InstReady_1;
  logic [31:0] o_Inst_32;
  logic [31:0] o_InstPc_32;

  modport master (
    output o_ImemReqValid_1, o_ImemAddr_32, o_InstValid_1, o_Inst_32, o_InstPc_32,
    input  i_ImemReqReady_1, i_ImemRespValid_1, i_ImemRespData_32, i_InstReady_1
  );

  modport slave (
    input  o_ImemReqValid_1, o_ImemAddr_32, o_InstValid_1, o_Inst_32, o_InstPc_32,
    output i_ImemReqReady_1, i_ImemRespValid_1, i_ImemRespData_32, i_InstReady_1
  );

endinterface

// File: rtl/pc_fetch_control_pc_next_select.sv
// Next-PC mux: hold, sequential step (wraps mod 2^32) or word-aligned jump
// target. With PC_MISALIGN_TRAP_EN it also flags a target that is not
// word aligned.
module pc_next_select
  import pc_fetch_control_pkg::*;
#(
  parameter int unsigned PC_STEP = PC_STEP_DEFAULT
) (
  input  logic [31:0] pc_i,
  input  logic [31:0] target_i,
  input  pc_sel_e     sel_i,
`ifdef PC_MISALIGN_TRAP_EN
  output logic        misalign_o,
`endif
  output logic [31:0] pc_o
);

  // Select the PC for the next cycle.
  always_comb begin
    pc_o = pc_i;
    case (sel_i)
      SEL_INC: pc_o = pc_i + 32'(PC_STEP);
      SEL_TGT: pc_o = align_word(target_i);
      default: pc_o = pc_i;
    endcase
  end

`ifdef PC_MISALIGN_TRAP_EN
  assign misalign_o = |target_i[1:0];
`endif

endmodule

// File: rtl/pc_fetch_control.sv
// Program counter and single-outstanding fetch sequencer.
// Optional feature macro: PC_MISALIGN_TRAP_EN (misaligned taken target traps
// instead of being silently word aligned).
module pc_fetch_control
  import pc_fetch_control_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic                i_Clk_1,
  input  logic                i_Rst_n_1,
  input  logic                i_RedirectValid_1,
  input  logic                i_Jump_1,
  input  logic [31:0]         i_JumpTarget_32,
  pc_fetch_control_if.master  bus,
  output logic                o_Flush_1,
`ifdef PC_MISALIGN_TRAP_EN
  output logic                o_Misalign_1,
`endif
  output fetch_state_e        o_State_3
);

  fetch_state_e        state_q, state_d;
  logic [31:0]         pc_q, pc_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic [31:0]         inst_pc_q, inst_pc_d;
  logic                flush_q, flush_d;
  pc_sel_e             pc_sel;
  logic                taken;
`ifdef PC_MISALIGN_TRAP_EN
  logic                misalign_q, misalign_d;
  logic                tgt_misalign;
`endif

  assign taken = i_RedirectValid_1 & i_Jump_1;

  pc_next_select #(.PC_STEP(PC_STEP)) u_pc_next_select (
    .pc_i       (pc_q),
    .target_i   (i_JumpTarget_32),
    .sel_i      (pc_sel),
`ifdef PC_MISALIGN_TRAP_EN
    .misalign_o (tgt_misalign),
`endif
    .pc_o       (pc_d)
  );

  // Next state and data: a taken redirect outranks every other event.
  always_comb begin
    state_d   = state_q;
    pc_sel    = SEL_HOLD;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    flush_d   = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    misalign_d = 1'b0;
`endif
    if (taken && state_q != ST_TRAP) begin
`ifdef PC_MISALIGN_TRAP_EN
      if (tgt_misalign) begin
        misalign_d = 1'b1;
        state_d    = ST_TRAP;
      end else
`endif
      begin
        pc_sel  = SEL_TGT;
        flush_d = 1'b1;
        case (state_q)
          // Accepted this cycle: its response is now stale.
          ST_REQ:   state_d = bus.i_ImemReqReady_1 ? ST_DRAIN : ST_REQ;
          // A response arriving this very cycle retires the outstanding
          // request, so there is nothing left to drain.
          ST_WAIT,
          ST_DRAIN: state_d = bus.i_ImemRespValid_1 ? ST_REQ : ST_DRAIN;
          default:  state_d = ST_REQ;
        endcase
      end
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_REQ;
        ST_REQ:   if (bus.i_ImemReqReady_1) state_d = ST_WAIT;
        ST_WAIT: begin
          if (bus.i_ImemRespValid_1) begin
            inst_d    = bus.i_ImemRespData_32;
            inst_pc_d = pc_q;
            pc_sel    = SEL_INC;
            state_d   = ST_HOLD;
          end
        end
        ST_HOLD:  if (bus.i_InstReady_1) state_d = ST_REQ;
        ST_DRAIN: if (bus.i_ImemRespValid_1) state_d = ST_REQ;
        ST_TRAP:  state_d = ST_TRAP;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge i_Clk_1) begin
    if (!i_Rst_n_1) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      inst_q     <= '0;
      inst_pc_q  <= '0;
      flush_q    <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      flush_q    <= flush_d;
`ifdef PC_MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign bus.o_ImemReqValid_1 = (state_q == ST_REQ);
  assign bus.o_ImemAddr_32    = pc_q;
  assign bus.o_InstValid_1    = (state_q == ST_HOLD);
  assign bus.o_Inst_32        = inst_q;
  assign bus.o_InstPc_32      = inst_pc_q;
  assign o_Flush_1            = flush_q;
`ifdef PC_MISALIGN_TRAP_EN
  assign o_Misalign_1         = misalign_q;
`endif
  assign o_State_3            = state_q;

endmodule
